// File: rtl/rgb_pwm_driver.sv
// PWM driver for the RGB status LED. Colour flags and duty are shadowed at period
// boundaries so comparator glitches and mid-period changes never reach the pins.
//
// state | meaning
// IDLE  | engine stopped, cnt held at 0, LEDs off
// RUN   | counting periods, shadow regs reload at every wrap
// DRAIN | en dropped, finishing the current period with frozen shadow regs
module rgb_pwm_driver #(
   parameter int   CNT_W      = 8,
   parameter logic ACTIVE_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             red,
   input  logic             green,
   input  logic             blue,
   input  logic [CNT_W-1:0] duty,
   output logic             led_r,
   output logic             led_g,
   output logic             led_b,
   output logic             period_start
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [CNT_W-1:0] MAX = '1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] sh_duty;
   logic             sh_r;
   logic             sh_g;
   logic             sh_b;
   logic             at_max;
   logic             pwm_on;

   assign at_max = (cnt == MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         sh_r    <= 1'b0;
         sh_g    <= 1'b0;
         sh_b    <= 1'b0;
         sh_duty <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (en) begin
                  state   <= RUN;
                  sh_r    <= red;
                  sh_g    <= green;
                  sh_b    <= blue;
                  sh_duty <= duty;
               end
            end
            RUN: begin
               cnt <= cnt + 1'b1;
               if (!en) begin
                  // Dropping en on the last cycle means the period is already complete.
                  state <= at_max ? IDLE : DRAIN;
               end else if (at_max) begin
                  sh_r    <= red;
                  sh_g    <= green;
                  sh_b    <= blue;
                  sh_duty <= duty;
               end
            end
            DRAIN: begin
               cnt <= cnt + 1'b1;
               if (at_max) begin
                  if (en) begin
                     state   <= RUN;
                     sh_r    <= red;
                     sh_g    <= green;
                     sh_b    <= blue;
                     sh_duty <= duty;
                  end else begin
                     state <= IDLE;
                  end
               end else if (en) begin
                  state <= RUN;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign pwm_on       = (state != IDLE) && (cnt < sh_duty);
   assign led_r        = (sh_r & pwm_on) ^ ACTIVE_LOW;
   assign led_g        = (sh_g & pwm_on) ^ ACTIVE_LOW;
   assign led_b        = (sh_b & pwm_on) ^ ACTIVE_LOW;
   assign period_start = (state == RUN) && (cnt == '0);

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver (CNT_W=4), with an inverted-polarity twin
// instance; a cycle model pushes expected pins into a queue checked after each edge.
module tb_rgb_pwm_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       red = 1'b0;
   logic       green = 1'b0;
   logic       blue = 1'b0;
   logic [3:0] duty = 4'd0;
   logic       led_r, led_g, led_b, period_start;
   logic       led_r_al, led_g_al, led_b_al, period_start_al;

   int checks = 0;
   int errors = 0;

   int   m_st = 0;
   int   m_cnt = 0;
   int   m_duty = 0;
   logic m_r = 1'b0, m_g = 1'b0, m_b = 1'b0;

   logic [3:0] exp_q[$];

   int ps_cnt, r_cnt, b_cnt, any_cnt;

   always #5 clk = ~clk;

   rgb_pwm_driver #(.CNT_W(4), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .red(red), .green(green), .blue(blue),
      .duty(duty), .led_r(led_r), .led_g(led_g), .led_b(led_b),
      .period_start(period_start)
   );

   rgb_pwm_driver #(.CNT_W(4), .ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst_n(rst_n), .en(en), .red(red), .green(green), .blue(blue),
      .duty(duty), .led_r(led_r_al), .led_g(led_g_al), .led_b(led_b_al),
      .period_start(period_start_al)
   );

   task automatic check_v(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic check_i(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic model_load();
      m_r    = red;
      m_g    = green;
      m_b    = blue;
      m_duty = int'(duty);
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         m_st = 0; m_cnt = 0; m_duty = 0;
         m_r = 1'b0; m_g = 1'b0; m_b = 1'b0;
      end else if (m_st == 0) begin
         m_cnt = 0;
         if (en) begin m_st = 1; model_load(); end
      end else if (m_st == 1) begin
         if (!en) begin
            m_st  = (m_cnt == 15) ? 0 : 2;
            m_cnt = (m_cnt + 1) % 16;
         end else if (m_cnt == 15) begin
            model_load();
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end else begin
         if (m_cnt == 15) begin
            if (en) begin m_st = 1; model_load(); end
            else m_st = 0;
            m_cnt = 0;
         end else begin
            m_cnt++;
            if (en) m_st = 1;
         end
      end
   endtask

   function automatic logic [3:0] model_pins();
      logic on;
      on = (m_st != 0) && (m_cnt < m_duty);
      return {m_r & on, m_g & on, m_b & on, logic'(m_st == 1 && m_cnt == 0)};
   endfunction

   task automatic clear_counts();
      ps_cnt = 0; r_cnt = 0; b_cnt = 0; any_cnt = 0;
   endtask

   task automatic tick();
      logic [3:0] e;
      @(posedge clk);
      model_edge();
      exp_q.push_back(model_pins());
      #1;
      e = exp_q.pop_front();
      check_v("pins", {led_r, led_g, led_b, period_start}, e);
      check_v("pins_active_low", {1'b0, led_r_al, led_g_al, led_b_al}, {1'b0, ~e[3:1]});
      ps_cnt  += int'(period_start);
      r_cnt   += int'(led_r);
      b_cnt   += int'(led_b);
      any_cnt += int'(led_r | led_g | led_b);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      clear_counts();
      // reset held with en=1
      rst_n = 1'b0; en = 1'b1; red = 1'b1; blue = 1'b1; duty = 4'd5;
      ticks(3);
      check_v("reset_pins", {led_r, led_g, led_b, period_start}, 4'b0000);
      check_v("reset_pins_al", {1'b0, led_r_al, led_g_al, led_b_al}, 4'b0111);

      // duty 5, red+blue
      rst_n = 1'b1; green = 1'b0;
      clear_counts();
      ticks(32);
      check_i("ps_per_2_periods", ps_cnt, 2);
      check_i("red_on_2_periods", r_cnt, 10);
      check_i("blue_on_2_periods", b_cnt, 10);
      ticks(8);                          // now at cnt 7

      // mid-period change takes effect only at wrap
      red = 1'b0; duty = 4'd10;
      clear_counts();
      ticks(8);                          // cnt 8..15
      check_i("no_midperiod_change_b", b_cnt, 0);
      check_i("no_midperiod_change_r", r_cnt, 0);
      clear_counts();
      ticks(16);
      check_i("new_duty_blue_on", b_cnt, 10);
      check_i("new_red_off", r_cnt, 0);

      // duty 0 for three periods
      duty = 4'd0;
      clear_counts();
      ticks(48);
      check_i("duty0_all_off", any_cnt, 0);
      check_i("duty0_ps_count", ps_cnt, 3);

      // duty MAX, all colours
      duty = 4'd15; red = 1'b1; green = 1'b1; blue = 1'b1;
      clear_counts();
      ticks(16);
      check_i("duty_max_red_on", r_cnt, 15);
      ticks(4);                          // cnt 3

      // drop en at cnt 3: drain to end of period then idle
      en = 1'b0;
      clear_counts();
      ticks(13);
      check_i("drain_red_on", r_cnt, 11);
      check_i("drain_no_ps", ps_cnt, 0);
      check_v("idle_after_drain", {led_r, led_g, led_b, period_start}, 4'b0000);
      clear_counts();
      ticks(2);
      check_i("idle_stays_off", any_cnt, 0);

      // re-raise en mid-drain: no reload until wrap
      en = 1'b1;
      tick();
      check_v("restart_ps", {3'b000, period_start}, 4'b0001);
      ticks(3);                          // cnt 3
      en = 1'b0;
      ticks(7);                          // cnt 10, draining
      red = 1'b0; en = 1'b1;
      clear_counts();
      ticks(5);                          // cnt 11..15
      check_i("reraise_no_reload_red", r_cnt, 4);
      check_i("reraise_no_ps", ps_cnt, 0);
      tick();                            // wrap with reload
      check_v("wrap_reload", {led_r, 2'b00, period_start}, 4'b0001);

      // reset mid-period
      ticks(9);                          // cnt 9
      rst_n = 1'b0;
      tick();
      check_v("midperiod_reset", {led_r, led_g, led_b, period_start}, 4'b0000);
      rst_n = 1'b1;
      tick();
      check_v("fresh_period_ps", {3'b000, period_start}, 4'b0001);
      ticks(4);

      check_i("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
